// File: rtl/uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter for the RV32I data-memory bus.
//   Stores to TXDATA queue bytes in a small FIFO. A serializer drains the FIFO
//   LSB first onto tx, with no idle gap between back-to-back frames.
//
//   Register window (word-aligned, relative to BASE_ADDR):
//     +0 TXDATA  W: push wdata[7:0]            R: 0
//     +4 STATUS  R: {16'h0, count[7:0], 5'h0, busy, empty, full}
//     +8 DROPS   R: saturating overflow count  W: any write clears it
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   mem_write  core store strobe
//   mem_read   core load strobe
//   addr       core data address
//   wdata      core store data (only [7:0] used)
//   hit        address falls on one of the three registers
//   rdata      read data, zero unless mem_read && hit
//   tx         serial output, idle high
//   busy       serializer active or FIFO non-empty
// -----------------------------------------------------------------------------
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [31:0]   ADDR_TXDATA = BASE_ADDR;
  localparam logic [31:0]   ADDR_STATUS = BASE_ADDR + 32'd4;
  localparam logic [31:0]   ADDR_DROPS  = BASE_ADDR + 32'd8;
  localparam logic [BW-1:0] BIT_LAST    = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_drops;

  // Serializer
  logic [1:0]    r_state;
  logic [BW-1:0] r_bit_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;

  logic        w_full;
  logic        w_empty;
  logic        w_bit_end;
  logic        w_pop;
  logic        w_wr_txdata;
  logic        w_push;
  logic        w_drop;
  logic        w_clr_drops;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_full    = (r_count == COUNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_bit_end = (r_bit_cnt == BIT_LAST);

  // A pop happens either from IDLE or on the last cycle of a stop bit, so the
  // next frame's start bit follows the stop bit with no gap.
  assign w_pop = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));

  assign w_wr_txdata = mem_write && (addr == ADDR_TXDATA);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push      = w_wr_txdata && (!w_full || w_pop);
  assign w_drop      = w_wr_txdata && w_full && !w_pop;
  assign w_clr_drops = mem_write && (addr == ADDR_DROPS);

  assign hit  = (addr == ADDR_TXDATA) || (addr == ADDR_STATUS) || (addr == ADDR_DROPS);
  assign busy = (r_state != S_IDLE) || !w_empty;

  assign w_status = {16'h0000, 8'(r_count), 5'b00000, busy, w_empty, w_full};
  assign w_unused = ^wdata[31:8];

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are valid, so resetting the data bits buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata[7:0];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear takes priority over a same-cycle overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drops <= '0;
    end else if (w_clr_drops) begin
      r_drops <= '0;
    end else if (w_drop && r_drops != 8'hFF) begin
      r_drops <= r_drops + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          r_idx     <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            r_idx     <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        default: begin  // S_STOP
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
      endcase
    end
  end

  // tx is decoded from registered state, so reset forces it high at once.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (mem_read && hit) begin
      case (addr)
        ADDR_STATUS: rdata = w_status;
        ADDR_DROPS:  rdata = {24'h000000, r_drops};
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_mmio
//   Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=8).
//   The reference model tracks the FIFO as a byte queue and the serializer as
//   "cycles left in the current frame"; the expected tx level is derived from
//   the position inside a 10-bit 8N1 frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * CPB;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read  = 1'b0;
  logic [31:0] addr      = '0;
  logic [31:0] wdata     = '0;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .addr     (addr),
    .wdata    (wdata),
    .hit      (hit),
    .rdata    (rdata),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_q[$];
  int         m_left  = 0;
  logic [7:0] m_cur   = '0;
  int         m_drops = 0;

  // tx level sampled once per cycle, and bytes recovered from it
  logic       tx_log[$];
  logic [7:0] rx_bytes[$];
  int         rx_starts[$];

  function automatic logic m_hit(input logic [31:0] a);
    return (a == BASE) || (a == BASE + 4) || (a == BASE + 8);
  endfunction

  function automatic logic m_busy();
    return (m_left > 0) || (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = '0;
    s[15:8] = 8'(m_q.size());
    s[2]    = m_busy();
    s[1]    = (m_q.size() == 0);
    s[0]    = (m_q.size() == DEPTH);
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == BASE + 4) return m_status();
    if (a == BASE + 8) return 32'(m_drops);
    return 32'h0;
  endfunction

  // Frame position p: bit slot 0 is start, 1..8 are data LSB first, 9 is stop.
  function automatic logic m_tx();
    int b;
    if (m_left == 0) return 1'b1;
    b = (FRAME - m_left) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  function automatic void m_edge(input logic w, input logic [31:0] a, input logic [7:0] d);
    logic pop;
    logic was_full;
    was_full = (m_q.size() == DEPTH);
    pop      = (m_q.size() > 0) && (m_left <= 1);
    if (pop) begin
      m_cur  = m_q.pop_front();
      m_left = FRAME;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (w && a == BASE) begin
      if (!was_full || pop) m_q.push_back(d);
      else if (m_drops < 255) m_drops++;
    end
    if (w && a == BASE + 8) m_drops = 0;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_left  = 0;
    m_drops = 0;
  endfunction

  function automatic void decode();
    int i;
    logic [7:0] b;
    rx_bytes.delete();
    rx_starts.delete();
    i = 1;
    while (i + FRAME <= tx_log.size()) begin
      if (tx_log[i] == 1'b0 && tx_log[i-1] == 1'b1) begin
        for (int k = 0; k < 8; k++) b[k] = tx_log[i + CPB*(k+1) + CPB/2];
        rx_bytes.push_back(b);
        rx_starts.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endfunction

  // One bus cycle: drive, check decode/read before the edge, then check
  // tx, busy, STATUS and DROPS against the model after the edge.
  task automatic cycle(input logic w, input logic r, input logic [31:0] a, input logic [7:0] d);
    logic [31:0] exp_rd;
    mem_write = w;
    mem_read  = r;
    addr      = a;
    wdata     = {24'($urandom), d};
    #1;
    n_vec++;
    if (hit !== m_hit(a)) begin
      n_err++;
      $display("FAIL hit addr=%h got %b exp %b", a, hit, m_hit(a));
    end
    exp_rd = r ? m_read(a) : 32'h0;
    n_vec++;
    if (rdata !== exp_rd) begin
      n_err++;
      $display("FAIL rdata addr=%h rd=%b got %h exp %h", a, r, rdata, exp_rd);
    end
    @(posedge clk);
    #1;
    m_edge(w, a, d);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    addr      = '0;
    n_vec++;
    if (tx !== m_tx()) begin
      n_err++;
      $display("FAIL tx t=%0t got %b exp %b", $time, tx, m_tx());
    end
    n_vec++;
    if (busy !== m_busy()) begin
      n_err++;
      $display("FAIL busy t=%0t got %b exp %b", $time, busy, m_busy());
    end
    mem_read = 1'b1;
    addr     = BASE + 4;
    #1;
    n_vec++;
    if (rdata !== m_status()) begin
      n_err++;
      $display("FAIL status t=%0t got %h exp %h", $time, rdata, m_status());
    end
    addr = BASE + 8;
    #1;
    n_vec++;
    if (rdata !== 32'(m_drops)) begin
      n_err++;
      $display("FAIL drops t=%0t got %h exp %h", $time, rdata, m_drops);
    end
    mem_read = 1'b0;
    addr     = '0;
    tx_log.push_back(tx);
  endtask

  task automatic drain();
    for (int i = 0; i < (DEPTH + 2) * FRAME && m_busy(); i++) cycle(1'b0, 1'b0, '0, '0);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain busy got %b exp 0", busy);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    mem_read = 1'b1;
    addr     = BASE + 4;
    #1;
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b exp 1", tx); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++;
    if (rdata !== 32'h0000_0002) begin n_err++; $display("FAIL reset_status got %h exp 00000002", rdata); end
    addr = BASE + 8;
    #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_drops got %h exp 0", rdata); end
    mem_read = 1'b0;
    addr     = '0;
    #6 reset = 1'b1;
    m_reset();
  endtask

  task automatic test_addr_decode();
    logic [31:0] probe [8];
    probe = '{BASE - 4, BASE, BASE + 1, BASE + 4, BASE + 6, BASE + 8, BASE + 12, BASE + 32'h10};
    cycle(1'b1, 1'b0, BASE + 32'h10, 8'hAA);
    cycle(1'b1, 1'b0, BASE + 2, 8'hBB);
    cycle(1'b1, 1'b0, BASE + 4, 8'hCC);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, probe[i], '0);
    mem_read = 1'b1;
    addr     = BASE + 4;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0002) begin n_err++; $display("FAIL decode_status got %h exp 00000002", rdata); end
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL decode_tx got %b exp 1", tx); end
    mem_read = 1'b0;
    addr     = '0;
  endtask

  task automatic test_single_byte();
    int fall;
    fall = -1;
    tx_log.delete();
    cycle(1'b1, 1'b0, BASE, 8'h55);
    for (int i = 0; i < FRAME + 4; i++) begin
      cycle(1'b0, 1'b0, '0, '0);
      if (!busy && fall < 0) fall = i + 1;
    end
    n_vec++;
    if (fall !== FRAME + 1) begin n_err++; $display("FAIL single_busy_fall got %0d exp %0d", fall, FRAME + 1); end
    decode();
    n_vec++;
    if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h55 || rx_starts[0] != 1) begin
      n_err++;
      $display("FAIL single_decode got n=%0d byte=%h start=%0d exp n=1 byte=55 start=1",
               rx_bytes.size(), rx_bytes.size() > 0 ? rx_bytes[0] : 8'h00,
               rx_starts.size() > 0 ? rx_starts[0] : -1);
    end
  endtask

  task automatic test_overflow();
    tx_log.delete();
    cycle(1'b1, 1'b0, BASE + 8, '0);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, BASE, 8'(8'h41 + k));
    mem_read = 1'b1;
    addr     = BASE + 4;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0805) begin n_err++; $display("FAIL overflow_status got %h exp 00000805", rdata); end
    addr = BASE + 8;
    #1;
    n_vec++;
    if (rdata !== 32'h1) begin n_err++; $display("FAIL overflow_drops got %h exp 00000001", rdata); end
    mem_read = 1'b0;
    cycle(1'b1, 1'b0, BASE + 8, 8'h77);
    mem_read = 1'b1;
    addr     = BASE + 8;
    #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL overflow_clear got %h exp 0", rdata); end
    mem_read = 1'b0;
    addr     = '0;
    drain();
    decode();
    n_vec++;
    if (rx_bytes.size() != 9) begin
      n_err++;
      $display("FAIL overflow_count got %0d exp 9", rx_bytes.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_vec++;
        if (rx_bytes[k] !== 8'(8'h41 + k)) begin
          n_err++;
          $display("FAIL overflow_byte%0d got %h exp %h", k, rx_bytes[k], 8'(8'h41 + k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    tx_log.delete();
    cycle(1'b1, 1'b0, BASE, 8'hA5);
    cycle(1'b1, 1'b0, BASE, 8'h3C);
    drain();
    decode();
    n_vec++;
    if (rx_bytes.size() != 2 || rx_bytes[0] !== 8'hA5 || rx_bytes[1] !== 8'h3C) begin
      n_err++;
      $display("FAIL b2b_bytes got n=%0d exp A5,3C", rx_bytes.size());
    end else begin
      n_vec++;
      if (rx_starts[1] - rx_starts[0] != FRAME) begin
        n_err++;
        $display("FAIL b2b_gap got %0d exp %0d", rx_starts[1] - rx_starts[0], FRAME);
      end
    end
  endtask

  task automatic test_push_pop_full();
    int guard;
    cycle(1'b1, 1'b0, BASE + 8, '0);
    for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, BASE, 8'(8'h60 + k));
    guard = 0;
    while (m_left != 1 && guard < 2 * FRAME) begin
      cycle(1'b0, 1'b0, '0, '0);
      guard++;
    end
    n_vec++;
    if (guard >= 2 * FRAME) begin n_err++; $display("FAIL pushpop_wait got timeout exp stop edge"); end
    cycle(1'b1, 1'b0, BASE, 8'hE7);
    mem_read = 1'b1;
    addr     = BASE + 4;
    #1;
    n_vec++;
    if (rdata[15:8] !== 8'd8 || rdata[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pushpop_status got %h exp count 8 full", rdata);
    end
    addr = BASE + 8;
    #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL pushpop_drops got %h exp 0", rdata); end
    mem_read = 1'b0;
    addr     = '0;
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, BASE, 8'(8'h41 + k));
    guard = 0;
    while (!(m_left > 0 && (FRAME - m_left) / CPB == 4) && guard < FRAME) begin
      cycle(1'b0, 1'b0, '0, '0);
      guard++;
    end
    // 0x41 has bit 3 clear, so the line is low right before reset.
    n_vec++;
    if (tx !== 1'b0) begin n_err++; $display("FAIL midrst_pre_tx got %b exp 0", tx); end
    reset = 1'b0;
    mem_read = 1'b1;
    addr     = BASE + 4;
    #1;
    n_vec++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx got %b exp 1", tx); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_vec++;
    if (rdata !== 32'h0000_0002) begin n_err++; $display("FAIL midrst_status got %h exp 00000002", rdata); end
    addr = BASE + 8;
    #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL midrst_drops got %h exp 0", rdata); end
    mem_read = 1'b0;
    addr     = '0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    tx_log.delete();
    cycle(1'b1, 1'b0, BASE, 8'h96);
    drain();
    decode();
    n_vec++;
    if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h96) begin
      n_err++;
      $display("FAIL midrst_after got n=%0d exp one byte 96", rx_bytes.size());
    end
  endtask

  task automatic test_drops_saturate();
    for (int k = 0; k < 300; k++) cycle(1'b1, 1'b0, BASE, 8'($urandom));
    mem_read = 1'b1;
    addr     = BASE + 8;
    #1;
    n_vec++;
    if (rdata !== 32'd255) begin n_err++; $display("FAIL drops_sat got %h exp 000000ff", rdata); end
    mem_read = 1'b0;
    addr     = '0;
    cycle(1'b1, 1'b0, BASE + 8, '0);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] rd_addr [5];
    logic [31:0] oow_addr [5];
    int sel;
    rd_addr  = '{BASE, BASE + 4, BASE + 8, BASE + 2, BASE + 12};
    oow_addr = '{BASE + 1, BASE + 3, BASE + 12, BASE + 32'h10, BASE - 4};
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(99));
      if (sel < 40)      cycle(1'b0, 1'b0, '0, '0);
      else if (sel < 70) cycle(1'b1, 1'b0, BASE, 8'($urandom));
      else if (sel < 75) cycle(1'b1, 1'b0, BASE + 4, 8'($urandom));
      else if (sel < 78) cycle(1'b1, 1'b0, BASE + 8, 8'($urandom));
      else if (sel < 93) cycle(1'b0, 1'b1, rd_addr[$urandom_range(4)], '0);
      else               cycle(1'b1, 1'b0, oow_addr[$urandom_range(4)], 8'($urandom));
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addr_decode();
    test_single_byte();
    test_overflow();
    test_back_to_back();
    test_push_pop_full();
    test_reset_mid_frame();
    test_drops_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the RV32I core's data-memory bus, directly downstream of the core's load/store path.
- Core stores to TXDATA push bytes into an internal FIFO. A serializer drains the FIFO onto a single tx line (8N1, LSB first).
- Gives the top-level bench and later FPGA builds a visible program output in place of waveform-only inspection.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 3-register window.
- CLKS_PER_BIT, 16, clock cycles per UART bit (≥2).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, 2..128).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_write  in  1  core store strobe, sampled on rising clk.
- mem_read  in  1  core load strobe.
- addr  in  32  core data address.
- wdata  in  32  core store data; only [7:0] used.
- hit  out  1  combinational: addr in [BASE_ADDR, BASE_ADDR+8] and word-aligned.
- rdata  out  32  combinational read data.
- tx  out  1  serial line, idle high.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Register map:
  - +0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - +4 STATUS (read-only): bit0 full, bit1 empty, bit2 busy, bits[15:8] FIFO count, other bits 0. Writes are ignored.
  - +8 DROPS: bits[7:0] saturating overflow counter (stops at 255). Any write clears it to 0.
- Unaligned or out-of-window addresses:
  - hit=0, rdata=0, no side effects.
- rdata:
  - Valid only when mem_read && hit; otherwise 32'h0.
  - Reads have no side effects.
- Reset (reset=0, asynchronous, any time including mid-frame):
  - tx=1, FSM=IDLE, FIFO empty (pointers and count 0), DROPS=0, busy=0.
  - Any partially sent frame is abandoned.
- Push rules:
  - Accepted when mem_write && addr==BASE+0 && (!full || pop in the same cycle).
  - Push while full with no pop: byte discarded, DROPS increments (saturating).
- FSM states: IDLE, START, DATA, STOP. The bit counter counts 0..CLKS_PER_BIT-1. The index counter counts 0..7.
  - IDLE: if FIFO non-empty at a rising edge → pop head into shift reg, go to START. tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right, 8 bits → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end: if FIFO non-empty, pop and go straight to START (no idle gap between frames); else IDLE.
- Latency:
  - Store to an empty FIFO with the FSM idle: byte enters FIFO at edge E0, is popped at E1, tx falls after E1.
  - Frame length exactly 10*CLKS_PER_BIT cycles.
- Simultaneous push and pop: count unchanged, both take effect.
- FIFO pointers wrap modulo FIFO_DEPTH.
- count ranges 0..FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- Simultaneous DROPS write-clear and overflow in the same cycle: clear wins (result 0).

Test Plan:
- Single byte (CLKS_PER_BIT=4): reset low 10ns, then store 0x55 to 0x1000.
  - tx goes low 1 clk after the store edge.
  - Then 4-clk bits 1,0,1,0,1,0,1,0, stop high.
  - busy falls after 40 clks.
- Overflow: 10 back-to-back stores 0x41..0x4A.
  - First byte is popped immediately; next 8 fill the FIFO; 10th is dropped.
  - STATUS read = 0x0000_0805 (count 8, full, busy).
  - DROPS = 1.
  - Write DROPS → reads 0.
- Back-to-back frames: store 0xA5 then 0x3C.
  - No idle cycle between the first stop bit and the second start bit.
  - Decoded bytes are 0xA5, 0x3C.
- Reset mid-frame: assert reset during DATA bit 3.
  - tx=1 immediately (asynchronously).
  - STATUS = 0x0000_0002, DROPS = 0.
  - After release, a new store transmits normally.
- Address decode: store to 0x1010 and 0x1002.
  - hit=0 for both, FIFO count stays 0, tx stays 1.
  - Load from 0x1004 with the FIFO empty returns 0x0000_0002.
- Push while full with a same-cycle pop: fill the FIFO, then store at the exact edge of the STOP→START pop.
  - Byte accepted, count stays 8, DROPS unchanged.
